// File: rtl/cam_pkg.sv
// Shared constants and FSM encoding for the CAM lookup/learn controller.
// Key 0 is reserved because empty CAM slots reset to 0 and would alias it.
package cam_pkg;

  localparam int KEY_W  = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  localparam logic [KEY_W-1:0] RESERVED_KEY = '0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEARCH = 3'd1,
    LOOKUP = 3'd2,
    INSERT = 3'd3,
    RESP   = 3'd4
  } state_t;

endpackage

// File: rtl/cam_alloc_ctr.sv
// Free-slot allocator for the CAM: a wrapping write pointer plus an occupancy
// count that saturates at DEPTH (no eviction, so full is sticky until reset).
module cam_alloc_ctr #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              inc,
  output logic [ADDR_W-1:0] alloc_ptr,
  output logic              full
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] ptr_reg;
  logic [CNT_W-1:0]  count_reg;

  assign alloc_ptr = ptr_reg;
  assign full      = (count_reg == CNT_W'(DEPTH));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ptr_reg   <= '0;
      count_reg <= '0;
    end else if (inc && !full) begin
      ptr_reg   <= (ptr_reg == ADDR_W'(DEPTH - 1)) ? '0 : ptr_reg + 1'b1;
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/cam_learn_ctrl.sv
// Lookup-or-learn controller driving the command port of an exact-match CAM.
// Search, read back the registered match address, optionally insert on miss.
module cam_learn_ctrl
  import cam_pkg::*;
#(
  parameter int KEY_W  = cam_pkg::KEY_W,
  parameter int ADDR_W = cam_pkg::ADDR_W,
  parameter int DEPTH  = cam_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [KEY_W-1:0]  req_key,
  input  logic              req_learn,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_hit,
  output logic              rsp_new,
  output logic              rsp_fail,
  output logic              cam_we,
  output logic [ADDR_W-1:0] cam_waddr,
  output logic [KEY_W-1:0]  cam_data,
  output logic              cam_search,
  input  logic [ADDR_W-1:0] cam_saddr,
  input  logic              cam_found
);

  localparam logic [KEY_W-1:0] RSV_KEY = KEY_W'(RESERVED_KEY);

  state_t            state_reg, state_next;
  logic [KEY_W-1:0]  key_reg;
  logic              learn_reg;
  logic              found_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              hit_reg, new_reg, fail_reg;
  logic [ADDR_W-1:0] alloc_ptr;
  logic              full;
  logic              alloc_inc;

  assign alloc_inc = (state_reg == INSERT);

  cam_alloc_ctr #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_alloc (
    .clk      (clk),
    .rstN     (rstN),
    .inc      (alloc_inc),
    .alloc_ptr(alloc_ptr),
    .full     (full)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Response fields are only written on the path into RESP, so they hold
  // steady for as long as the consumer stalls.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      key_reg   <= '0;
      learn_reg <= 1'b0;
      found_reg <= 1'b0;
      addr_reg  <= '0;
      hit_reg   <= 1'b0;
      new_reg   <= 1'b0;
      fail_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            key_reg   <= req_key;
            learn_reg <= req_learn;
            addr_reg  <= '0;
            hit_reg   <= 1'b0;
            new_reg   <= 1'b0;
            fail_reg  <= (req_key == RSV_KEY);
          end
        end
        SEARCH: found_reg <= cam_found;
        LOOKUP: begin
          if (found_reg) begin
            addr_reg <= cam_saddr;
            hit_reg  <= 1'b1;
          end else if (learn_reg && full) begin
            fail_reg <= 1'b1;
          end
        end
        INSERT: begin
          addr_reg <= alloc_ptr;
          new_reg  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    cam_we     = 1'b0;
    cam_search = 1'b0;
    cam_waddr  = '0;
    cam_data   = '0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = (req_key == RSV_KEY) ? RESP : SEARCH;
      end
      SEARCH: begin
        cam_data   = key_reg;
        cam_search = 1'b1;
        state_next = LOOKUP;
      end
      LOOKUP: begin
        // Search stays asserted so the CAM keeps cam_saddr valid this cycle.
        cam_data   = key_reg;
        cam_search = 1'b1;
        if (!found_reg && learn_reg && !full) state_next = INSERT;
        else                                  state_next = RESP;
      end
      INSERT: begin
        cam_we     = 1'b1;
        cam_waddr  = alloc_ptr;
        cam_data   = key_reg;
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rsp_addr = addr_reg;
  assign rsp_hit  = hit_reg;
  assign rsp_new  = new_reg;
  assign rsp_fail = fail_reg;

endmodule

// File: tb/tb_cam_learn_ctrl.sv
// Scoreboard bench for cam_learn_ctrl with a behavioural 16x16 CAM attached
// and an associative-array reference model of lookup/learn outcomes.
module tb_cam_learn_ctrl;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_key = '0;
  logic        req_learn = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [3:0]  rsp_addr;
  logic        rsp_hit, rsp_new, rsp_fail;
  logic        cam_we;
  logic [3:0]  cam_waddr;
  logic [15:0] cam_data;
  logic        cam_search;
  logic [3:0]  cam_saddr;
  logic        cam_found;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cam_learn_ctrl dut (
    .clk(clk), .rstN(rstN),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key), .req_learn(req_learn),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
    .rsp_hit(rsp_hit), .rsp_new(rsp_new), .rsp_fail(rsp_fail),
    .cam_we(cam_we), .cam_waddr(cam_waddr), .cam_data(cam_data), .cam_search(cam_search),
    .cam_saddr(cam_saddr), .cam_found(cam_found)
  );

  // Behavioural CAM: entries reset to 0, lowest matching index wins.
  logic [15:0] cam_mem [16];
  always_comb begin
    cam_found = 1'b0;
    for (int i = 0; i < 16; i++) if (cam_mem[i] == cam_data) cam_found = 1'b1;
  end
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < 16; i++) cam_mem[i] <= '0;
      cam_saddr <= '0;
    end else begin
      if (cam_we) cam_mem[cam_waddr] <= cam_data;
      if (cam_search) begin
        for (int i = 15; i >= 0; i--) if (cam_mem[i] == cam_data) cam_saddr <= 4'(i);
      end
    end
  end

  typedef struct {
    logic [3:0] addr;
    bit hit; bit nw; bit fail;
    int lat; int we; int srch; int acc; int hold;
  } exp_t;

  exp_t q[$];
  logic [3:0] mtab [logic [15:0]];
  int mcount = 0;

  // Reference: key 0 rejected; known key hits; unknown key inserted at the
  // next sequential slot while fewer than 16 keys have been learned.
  function automatic exp_t model(input logic [15:0] k, input bit l);
    exp_t e;
    e = '{default: 0};
    if (k == 16'h0000) begin
      e.fail = 1; e.lat = 1;
    end else if (mtab.exists(k)) begin
      e.hit = 1; e.addr = mtab[k]; e.lat = 3; e.srch = 2;
    end else if (!l) begin
      e.lat = 3; e.srch = 2;
    end else if (mcount == 16) begin
      e.fail = 1; e.lat = 3; e.srch = 2;
    end else begin
      e.nw = 1; e.addr = 4'(mcount); e.lat = 4; e.srch = 2; e.we = 1;
      mtab[k] = 4'(mcount);
      mcount++;
    end
    return e;
  endfunction

  task automatic model_reset();
    mtab.delete();
    mcount = 0;
    q.delete();
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic send(input logic [15:0] k, input bit l, input int hold);
    exp_t e;
    int g;
    req_key = k; req_learn = l; req_valid = 1'b1; g = 0;
    while (!req_ready && g < 300) begin @(negedge clk); g++; end
    if (!req_ready) begin
      compared++; mismatched++;
      $display("FAIL accept_timeout key=%h: req_ready stayed 0, required 1", k);
      req_valid = 1'b0;
      return;
    end
    e = model(k, l);
    e.acc = cyc + 1;
    e.hold = hold;
    q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  bit         in_rsp = 0;
  int         hold_left = 0;
  int         we_cnt = 0, srch_cnt = 0;
  logic [6:0] held;
  exp_t       cur;

  always @(negedge clk) begin
    if (!rstN) begin
      in_rsp = 0; hold_left = 0; rsp_ready = 1'b0; we_cnt = 0; srch_cnt = 0;
    end else begin
      compared++;
      if (cam_we && cam_search) begin
        mismatched++;
        $display("FAIL cam_exclusive: we=1 search=1 together, required not both");
      end
      if (cam_we) we_cnt++;
      if (cam_search) srch_cnt++;
      if (rsp_valid) begin
        if (!in_rsp) begin
          in_rsp = 1;
          held = {rsp_addr, rsp_hit, rsp_new, rsp_fail};
          if (q.size() == 0) begin
            compared++; mismatched++; hold_left = 0;
            $display("FAIL unexpected_rsp: response with nothing outstanding");
          end else begin
            cur = q.pop_front();
            compared++;
            if (held !== {cur.addr, cur.hit, cur.nw, cur.fail}) begin
              mismatched++;
              $display("FAIL rsp_fields: got addr=%0d hit=%b new=%b fail=%b, required addr=%0d hit=%b new=%b fail=%b",
                       rsp_addr, rsp_hit, rsp_new, rsp_fail, cur.addr, cur.hit, cur.nw, cur.fail);
            end
            compared++;
            if (cyc - cur.acc + 1 != cur.lat) begin
              mismatched++;
              $display("FAIL rsp_latency: got %0d cycles, required %0d", cyc - cur.acc + 1, cur.lat);
            end
            compared++;
            if (we_cnt != cur.we || srch_cnt != cur.srch) begin
              mismatched++;
              $display("FAIL cam_strobes: got we=%0d search=%0d cycles, required we=%0d search=%0d",
                       we_cnt, srch_cnt, cur.we, cur.srch);
            end
            $display("rsp: addr=%0d hit=%b new=%b fail=%b lat=%0d", rsp_addr, rsp_hit, rsp_new, rsp_fail,
                     cyc - cur.acc + 1);
            hold_left = cur.hold;
          end
          we_cnt = 0; srch_cnt = 0;
        end else begin
          compared++;
          if ({rsp_addr, rsp_hit, rsp_new, rsp_fail} !== held) begin
            mismatched++;
            $display("FAIL rsp_stable: got %h, required %h", {rsp_addr, rsp_hit, rsp_new, rsp_fail}, held);
          end
          compared++;
          if (req_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL stall_req_ready: got %b, required 0", req_ready);
          end
        end
        if (hold_left > 0) begin rsp_ready = 1'b0; hold_left--; end
        else begin rsp_ready = 1'b1; in_rsp = 0; end
      end else begin
        rsp_ready = 1'b0;
      end
    end
  end

  task automatic drain();
    int g;
    g = 0;
    while ((q.size() != 0 || rsp_valid || in_rsp) && g < 500) begin @(negedge clk); g++; end
    if (g >= 500) begin
      compared++; mismatched++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", q.size());
    end
  endtask

  task automatic chk_reset_outs(input string name);
    logic [30:0] got;
    got = {req_ready, rsp_valid, rsp_addr, rsp_hit, rsp_new, rsp_fail, cam_we, cam_search, cam_waddr, cam_data};
    compared++;
    if (got !== {1'b1, 30'b0}) begin
      mismatched++;
      $display("FAIL %s: outputs=%h, required %h", name, got, {1'b1, 30'b0});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstN = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_outs("reset_outputs");
    rstN = 1'b1;
    @(negedge clk);
  endtask

  logic [15:0] pool [24];

  initial begin
    int g;
    bit l;
    logic [15:0] k;
    for (int i = 0; i < 24; i++) pool[i] = 16'h3000 + 16'(i * 7 + 1);

    do_reset();
    send(16'h1234, 1, 0);
    send(16'h1234, 0, 0);
    drain();

    do_reset();
    send(16'h5555, 0, 0);
    send(16'h0000, 1, 0);
    for (int i = 1; i <= 16; i++) send(16'hA000 + 16'(i), 1, 0);
    send(16'hBEEF, 1, 0);
    send(16'hA00F, 0, 5);
    send(16'h1234, 0, 0);
    drain();

    // Abort a learn while the write strobe is up.
    do_reset();
    send(16'h00FF, 1, 0);
    g = 0;
    while (!cam_we && g < 10) begin @(negedge clk); g++; end
    compared++;
    if (!cam_we) begin
      mismatched++;
      $display("FAIL insert_reach: cam_we never rose, required 1");
    end
    rstN = 1'b0;
    #1;
    chk_reset_outs("reset_mid_insert");
    model_reset();
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    send(16'h00FF, 1, 0);
    send(16'h00FF, 0, 1);
    drain();

    do_reset();
    for (int n = 0; n < 80; n++) begin
      k = ($urandom_range(0, 9) == 0) ? 16'h0000 : pool[$urandom_range(0, 23)];
      l = ($urandom_range(0, 9) < 7);
      send(k, l, int'($urandom_range(0, 3)));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
